out_fm_mem_port: RTL and testbench

- Memory-side engine for the output feature-map buffer.
- Load direction: fetches one out_fm tile (Tn*Tr*Tc words) from external memory and pushes it into the out_fm load FIFO, which the buffer pops.
- Store direction: pops the out_fm store FIFO, which the buffer fills, and writes the tile back to external memory.
- Load and store never overlap; a single FSM serialises them.

---
 rtl/out_fm_mem_port.sv | 221 ++++++++++++++++++++++
 tb/tb_out_fm_mem_port.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fm_mem_port.sv
// Memory-side engine for the out_fm buffer: loads a tile from external memory into the load FIFO,
// or drains the store FIFO back to memory. Define OUT_FM_MEM_PERF_EN to add the stall_cnt output.
module out_fm_mem_port #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int Tn        = 16,
    parameter int Tr        = 64,
    parameter int Tc        = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          st_start,
    input  logic [AW-1:0] base_addr,
    output logic          ld_done,
    output logic          st_done,
    output logic          busy,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_rd_addr,
    input  logic          mem_rd_gnt,
    input  logic          mem_rd_valid,
    input  logic [DW-1:0] mem_rd_data,
    output logic          mem_wr_req,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic          mem_wr_gnt,
    output logic          out_fm_ld_fifo_push,
    output logic [DW-1:0] out_fm_ld_fifo_data,
    input  logic          out_fm_ld_fifo_almost_full,
    output logic          out_fm_st_fifo_pop,
    input  logic [DW-1:0] out_fm_st_fifo_data,
    input  logic          out_fm_st_fifo_empty
`ifdef OUT_FM_MEM_PERF_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int TILE = Tn * Tr * Tc;
    localparam int CW   = $clog2(TILE + 1);
    localparam int OW   = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] TILE_C = CW'(TILE);
    localparam logic [CW-1:0] LAST_C = CW'(TILE - 1);
    localparam logic [OW-1:0] MAXO_C = OW'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_LD, S_ST} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] received_q, received_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [CW-1:0] popped_q, popped_d;
    logic [CW-1:0] written_q, written_d;
    logic          pend_q, pend_d;
    logic          hold_q, hold_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          wr_cur;
    logic          rd_hs;
    logic          wr_hs;

    always_comb begin
        state_d             = state_q;
        base_d              = base_q;
        issued_d            = issued_q;
        received_d          = received_q;
        outst_d             = outst_q;
        popped_d            = popped_q;
        written_d           = written_q;
        pend_d              = 1'b0;
        hold_d              = 1'b0;
        hold_data_d         = hold_data_q;
        ld_done             = 1'b0;
        st_done             = 1'b0;
        mem_rd_req          = 1'b0;
        out_fm_ld_fifo_push = 1'b0;
        out_fm_st_fifo_pop  = 1'b0;
        rd_hs               = 1'b0;
        wr_hs               = 1'b0;

        // Write slot: a word popped last cycle arrives straight from the FIFO; a refused word is parked in hold.
        wr_cur      = hold_q | pend_q;
        mem_wr_data = hold_q ? hold_data_q : (pend_q ? out_fm_st_fifo_data : '0);

        case (state_q)
            S_IDLE: begin
                if (ld_start || st_start) begin
                    state_d    = ld_start ? S_LD : S_ST;
                    base_d     = base_addr;
                    issued_d   = '0;
                    received_d = '0;
                    outst_d    = '0;
                    popped_d   = '0;
                    written_d  = '0;
                end
            end

            S_LD: begin
                mem_rd_req = (issued_q < TILE_C) && (outst_q < MAXO_C) && !out_fm_ld_fifo_almost_full;
                rd_hs      = mem_rd_req && mem_rd_gnt;
                if (rd_hs) begin
                    issued_d = issued_q + CW'(1);
                end
                case ({rd_hs, mem_rd_valid})
                    2'b10:   outst_d = outst_q + OW'(1);
                    2'b01:   outst_d = outst_q - OW'(1);
                    default: outst_d = outst_q;
                endcase
                // Returned data is always pushed; almost_full only throttles new requests.
                if (mem_rd_valid) begin
                    out_fm_ld_fifo_push = 1'b1;
                    received_d          = received_q + CW'(1);
                    if (received_q == LAST_C) begin
                        ld_done = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_ST: begin
                out_fm_st_fifo_pop = !out_fm_st_fifo_empty && (popped_q < TILE_C) &&
                                     (!wr_cur || mem_wr_gnt);
                if (out_fm_st_fifo_pop) begin
                    popped_d = popped_q + CW'(1);
                end
                pend_d = out_fm_st_fifo_pop;
                wr_hs  = wr_cur && mem_wr_gnt;
                hold_d = wr_cur && !mem_wr_gnt;
                if (hold_d) begin
                    hold_data_d = mem_wr_data;
                end
                if (wr_hs) begin
                    written_d = written_q + CW'(1);
                    if (written_q == LAST_C) begin
                        st_done = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy                = (state_q != S_IDLE);
    assign mem_rd_addr         = base_q + AW'(issued_q);
    assign mem_wr_addr         = base_q + AW'(written_q);
    assign mem_wr_req          = wr_cur;
    assign out_fm_ld_fifo_data = out_fm_ld_fifo_push ? mem_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            popped_q   <= '0;
            written_q  <= '0;
            pend_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            outst_q    <= outst_d;
            popped_q   <= popped_d;
            written_q  <= written_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
        end
    end

    // Held write data is qualified by hold_q, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
    end

`ifdef OUT_FM_MEM_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_inc;

    always_comb begin
        stall_d   = stall_q;
        stall_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_start || st_start) begin
                    stall_d = '0;
                end
            end
            S_LD: begin
                stall_inc = ((issued_q < TILE_C) &&
                             (out_fm_ld_fifo_almost_full || (outst_q == MAXO_C))) ||
                            (mem_rd_req && !mem_rd_gnt);
            end
            S_ST: begin
                stall_inc = (wr_cur && !mem_wr_gnt) ||
                            (out_fm_st_fifo_empty && (popped_q < TILE_C));
            end
            default: stall_inc = 1'b0;
        endcase
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_out_fm_mem_port.sv
// Scoreboard bench for out_fm_mem_port with an 8-word tile (Tn=2, Tr=2, Tc=2, MAX_OUTST=4).
module tb_out_fm_mem_port;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TILE = 8;
  localparam logic [DW-1:0] KEY = 32'h5A5A_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_start, st_start;
  logic [AW-1:0] base_addr;
  logic          ld_done, st_done, busy;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_gnt, mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_gnt;
  logic          ld_push;
  logic [DW-1:0] ld_data;
  logic          ld_af;
  logic          st_pop;
  logic [DW-1:0] st_data;
  logic          st_empty;
`ifdef OUT_FM_MEM_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  out_fm_mem_port #(
    .AW(AW), .DW(DW), .Tn(2), .Tr(2), .Tc(2), .MAX_OUTST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .st_start(st_start), .base_addr(base_addr),
    .ld_done(ld_done), .st_done(st_done), .busy(busy),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_gnt(mem_wr_gnt),
    .out_fm_ld_fifo_push(ld_push), .out_fm_ld_fifo_data(ld_data),
    .out_fm_ld_fifo_almost_full(ld_af),
    .out_fm_st_fifo_pop(st_pop), .out_fm_st_fifo_data(st_data), .out_fm_st_fifo_empty(st_empty)
`ifdef OUT_FM_MEM_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: actual=event required=no event", name);
  endtask

  // Scoreboard queues filled by the stimulus
  logic [AW-1:0] exp_rd_addr[$];
  logic [DW-1:0] exp_push[$];
  logic [AW-1:0] exp_wr_addr[$];
  logic [DW-1:0] exp_wr_data[$];

  // Memory and store-FIFO environment
  typedef struct { int due; logic [AW-1:0] addr; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] sq[$];
  int            sq_cnt = 0;
  logic          hold_rd = 1'b0, wr_toggle = 1'b0, force_empty = 1'b0;
  logic          env_hs, env_pop;
  logic [AW-1:0] env_a;
  int            cyc = 0;

  assign st_empty = force_empty || (sq_cnt == 0);

  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    st_data      = '0;
    mem_wr_gnt   = 1'b1;
    forever begin
      @(negedge clk);
      env_hs  = mem_rd_req && mem_rd_gnt;
      env_a   = mem_rd_addr;
      env_pop = st_pop;
      @(posedge clk);
      #1;
      cyc++;
      if (env_hs) pend.push_back('{cyc + 1, env_a});
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      if (!hold_rd && pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = pend[0].addr ^ KEY;
        void'(pend.pop_front());
      end
      if (env_pop && sq.size() > 0) st_data = sq.pop_front();
      else                          st_data = 32'hBAD0_BAD0;
      sq_cnt     = sq.size();
      mem_wr_gnt = wr_toggle ? !mem_wr_gnt : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer
  int            rd_hs_cnt = 0, push_cnt = 0, wr_cnt = 0, ld_done_cnt = 0, st_done_cnt = 0;
  logic          wr_prev_pend = 1'b0;
  logic [AW-1:0] wr_prev_addr;
  logic [DW-1:0] wr_prev_data;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_prev_pend = 1'b0;
      end else begin
        if (mem_rd_req && mem_rd_gnt) begin
          rd_hs_cnt++;
          if (exp_rd_addr.size() == 0) flag("unexpected_rd_grant");
          else chk("rd_addr", mem_rd_addr, exp_rd_addr.pop_front());
        end
        if (ld_push) begin
          push_cnt++;
          if (exp_push.size() == 0) flag("unexpected_push");
          else chk("push_data", ld_data, exp_push.pop_front());
        end
        if (ld_done) begin
          ld_done_cnt++;
          chk("ld_done_on_last_push", {ld_push, exp_push.size() == 0}, 2'b11);
        end
        if (wr_prev_pend)
          chk("wr_stable", {mem_wr_req, mem_wr_addr, mem_wr_data}, {1'b1, wr_prev_addr, wr_prev_data});
        wr_prev_pend = mem_wr_req && !mem_wr_gnt;
        wr_prev_addr = mem_wr_addr;
        wr_prev_data = mem_wr_data;
        if (mem_wr_req && mem_wr_gnt) begin
          wr_cnt++;
          if (exp_wr_addr.size() == 0) flag("unexpected_wr_grant");
          else begin
            chk("wr_addr", mem_wr_addr, exp_wr_addr.pop_front());
            chk("wr_data", mem_wr_data, exp_wr_data.pop_front());
          end
        end
        if (st_done) begin
          st_done_cnt++;
          chk("st_done_on_last_gnt", {mem_wr_req && mem_wr_gnt, exp_wr_addr.size() == 0}, 2'b11);
        end
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy, ld_done, st_done, mem_rd_req, mem_wr_req, ld_push, st_pop}, '0);
    chk({tag, "_addr"}, {mem_rd_addr, mem_wr_addr}, '0);
    chk({tag, "_data"}, {mem_wr_data, ld_data}, '0);
  endtask

  task automatic start_op(input logic ld, input logic st, input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    ld_start  = ld;
    st_start  = st;
    base_addr = base;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    st_start = 1'b0;
  endtask

  task automatic expect_load(input logic [AW-1:0] base);
    for (int i = 0; i < TILE; i++) begin
      exp_rd_addr.push_back(base + AW'(i));
      exp_push.push_back((base + AW'(i)) ^ KEY);
    end
  endtask

  task automatic expect_store(input logic [AW-1:0] base, input logic [DW-1:0] d0);
    for (int i = 0; i < TILE; i++) begin
      sq.push_back(d0 + DW'(i));
      exp_wr_addr.push_back(base + AW'(i));
      exp_wr_data.push_back(d0 + DW'(i));
    end
  endtask

  task automatic wait_ld_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ld_done && n < 400);
    if (!ld_done) flag({name, "_ld_done_timeout"});
  endtask

  task automatic wait_st_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!st_done && n < 400);
    if (!st_done) flag({name, "_st_done_timeout"});
  endtask

  int hs0, p0, d0, n, g, wcyc;
  logic started;

  initial begin
    rst_n = 1'b0; ld_start = 1'b0; st_start = 1'b0; base_addr = '0;
    mem_rd_gnt = 1'b1; ld_af = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic load at 0x100
    expect_load(32'h100);
    start_op(1'b1, 1'b0, 32'h100);
    @(negedge clk);
    chk("A_first_req", {mem_rd_req, busy, mem_rd_addr}, {1'b1, 1'b1, 32'h100});
    wait_ld_done("A");
    @(negedge clk);
    chk("A_busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
    chk("A_counts", {ld_done_cnt[7:0], push_cnt[7:0], rd_hs_cnt[7:0]}, {8'd1, 8'd8, 8'd8});

    // Read data withheld: outstanding limit caps grants at 4
    hold_rd = 1'b1;
    hs0 = rd_hs_cnt;
    expect_load(32'h2000);
    start_op(1'b1, 1'b0, 32'h2000);
    repeat (10) @(negedge clk);
    chk("B_req_blocked", mem_rd_req, 1'b0);
    @(posedge clk); #1;
    chk("B_grants", rd_hs_cnt - hs0, 4);
    hold_rd = 1'b0;
    wait_ld_done("B");
    @(posedge clk); #1;
    chk("B_counts", {ld_done_cnt[7:0], push_cnt[7:0]}, {8'd2, 8'd16});

    // almost_full raised after two grants
    hs0 = rd_hs_cnt; p0 = push_cnt;
    expect_load(32'h40);
    start_op(1'b1, 1'b0, 32'h40);
    n = 0; g = 0;
    while (g < 2 && n < 100) begin
      @(negedge clk); n++;
      if (mem_rd_req && mem_rd_gnt) g++;
    end
    if (g < 2) flag("C_grant_timeout");
    @(posedge clk); #1 ld_af = 1'b1;
    repeat (8) @(negedge clk);
    chk("C_req_held_off", mem_rd_req, 1'b0);
    @(posedge clk); #1;
    chk("C_grants_and_pushes", {rd_hs_cnt[7:0] - hs0[7:0], push_cnt[7:0] - p0[7:0]}, {8'd2, 8'd2});
    ld_af = 1'b0;
    wait_ld_done("C");
    @(posedge clk); #1;
    chk("C_ld_done_cnt", ld_done_cnt, 3);

    // Store with toggling write grant
    wr_toggle = 1'b1;
    expect_store(32'h3000, 32'hD000_0000);
    @(posedge clk);
    start_op(1'b0, 1'b1, 32'h3000);
    @(negedge clk);
    chk("D_first_pop", {st_pop, busy, mem_wr_req}, 3'b110);
    @(negedge clk);
    chk("D_first_wr", {mem_wr_req, mem_wr_addr}, {1'b1, 32'h3000});
    wait_st_done("D");
    @(negedge clk);
    chk("D_busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
    chk("D_counts", {st_done_cnt[7:0], wr_cnt[7:0]}, {8'd1, 8'd8});
    wr_toggle = 1'b0;

    // Simultaneous starts: load wins; then abort by reset after two pushes
    expect_store(32'h500, 32'hE000_0000);
    @(posedge clk);
    expect_load(32'h400);
    d0 = ld_done_cnt; p0 = push_cnt;
    start_op(1'b1, 1'b1, 32'h400);
    @(negedge clk);
    chk("E_load_wins", {mem_rd_req, st_pop, mem_rd_addr}, {1'b1, 1'b0, 32'h400});
    n = 0; g = 0;
    while (g < 2 && n < 100) begin
      @(negedge clk); n++;
      if (ld_push) g++;
    end
    if (g < 2) flag("E_push_timeout");
    #1 rst_n = 1'b0;
    #1;
    check_reset_outs("E_abort");
    exp_rd_addr.delete();
    exp_push.delete();
    repeat (3) @(negedge clk);
    check_reset_outs("E_in_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("E_no_done_no_stale_push", {ld_done_cnt[7:0], push_cnt[7:0]}, {d0[7:0], p0[7:0] + 8'd2});

    // Store after abort, continuous grant: one word per cycle
    start_op(1'b0, 1'b1, 32'h500);
    n = 0; wcyc = 0; started = 1'b0;
    do begin
      @(negedge clk); n++;
      if (mem_wr_req) started = 1'b1;
      if (started) wcyc++;
    end while (!st_done && n < 400);
    if (!st_done) flag("F_st_done_timeout");
    else chk("F_throughput_cycles", wcyc, 8);
    @(posedge clk); #1;
    chk("F_counts", {st_done_cnt[7:0], wr_cnt[7:0]}, {8'd2, 8'd16});

`ifdef OUT_FM_MEM_PERF_EN
    // Store stalled five cycles on an empty FIFO
    force_empty = 1'b1;
    expect_store(32'h600, 32'hC000_0000);
    @(posedge clk);
    start_op(1'b0, 1'b1, 32'h600);
    repeat (5) @(posedge clk);
    #1 force_empty = 1'b0;
    wait_st_done("G");
    chk("G_stall_cnt", stall_cnt, 32'd5);
`endif

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
